// File: rtl/lap_stopwatch.sv
// ---------------------------------------------------------------------------
// lap_stopwatch
//
// Purpose:
//   Up/down modulo-(MAX+1) stopwatch with a clock prescaler, a start/stop/
//   clear run control and a small lap-capture FIFO.
//
//   Control priority each cycle is clear > stop > (start | running).
//   An "active" cycle advances the prescaler; the count steps (and samples
//   dir) only on the cycle the prescaler rolls over from PRESCALE-1 to 0.
//   Any step that crosses the terminal boundary (MAX->0 counting up, 0->MAX
//   counting down) raises wrap for exactly the following cycle.
//
//   A lap request pushes the count as it was before the clock edge, no
//   matter what the run control does in the same cycle. The FIFO head is
//   presented combinationally from registered storage. A push into a full
//   FIFO with no simultaneous pop is dropped and sets the sticky
//   lap_overflow flag, which only reset clears.
//
// Parameters:
//   DATA_WIDTH  count width in bits
//   MAX         terminal count, MAX < 2**DATA_WIDTH
//   PRESCALE    active cycles per count step, >= 1
//   LAP_DEPTH   lap FIFO entries, power of two, >= 2
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   resetn        in   asynchronous active-low reset
//   start         in   begin or resume counting
//   stop          in   pause counting, hold count and prescaler
//   clear         in   synchronous zero of count, prescaler and run state
//   dir           in   0 = count up, 1 = count down (sampled on steps)
//   lap           in   capture current count into the lap FIFO
//   lap_rd        in   pop the lap FIFO head
//   count         out  current count (registered)
//   running       out  run state (registered)
//   wrap          out  one-cycle pulse after a wrap-around step
//   lap_data      out  FIFO head, meaningful when lap_valid = 1
//   lap_valid     out  FIFO non-empty
//   lap_full      out  FIFO holds LAP_DEPTH entries
//   lap_overflow  out  sticky: a lap capture was dropped
// ---------------------------------------------------------------------------
module lap_stopwatch #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int PRESCALE   = 1,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  dir,
  input  logic                  lap,
  input  logic                  lap_rd,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  output logic [DATA_WIDTH-1:0] lap_data,
  output logic                  lap_valid,
  output logic                  lap_full,
  output logic                  lap_overflow
);

  // Prescaler needs at least one bit even when PRESCALE = 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = $clog2(LAP_DEPTH);

  localparam logic [DATA_WIDTH-1:0] MAX_V    = DATA_WIDTH'(MAX);
  localparam logic [DATA_WIDTH-1:0] ONE_V    = DATA_WIDTH'(1);
  localparam logic [PW-1:0]         PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]         PRE_ONE  = PW'(1);
  localparam logic [AW:0]           PTR_ONE  = (AW + 1)'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // -------------------------------------------------------------------------
  // Counter, prescaler and run control
  // -------------------------------------------------------------------------
  run_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  wrap_q,  wrap_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (start || (state_q == ST_RUN)) begin
      state_d = ST_RUN;
      if (presc_q == PRE_LAST) begin
        // Step cycle: this is the only place dir has any effect.
        presc_d = '0;
        if (!dir) begin
          if (count_q == MAX_V) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + ONE_V;
          end
        end else begin
          if (count_q == '0) begin
            count_d = MAX_V;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - ONE_V;
          end
        end
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == ST_RUN);
  assign wrap    = wrap_q;

  // -------------------------------------------------------------------------
  // Lap FIFO
  //
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  ovf_q,    ovf_d;
  logic                  fifo_empty, fifo_full;
  logic                  do_push, do_pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a push when it is popped simultaneously. When full, the write
  // slot and the head slot coincide; the head is consumed by that pop.
  assign do_pop  = lap_rd && !fifo_empty;
  assign do_push = lap && (!fifo_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (lap && fifo_full && !do_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers empties
  // the FIFO, and stale entries are never visible because lap_data is gated
  // by lap_valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= count_q;
    end
  end

  assign lap_valid    = !fifo_empty;
  assign lap_full     = fifo_full;
  assign lap_overflow = ovf_q;
  assign lap_data     = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_lap_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_lap_stopwatch
//
// Two stopwatch instances share one stimulus stream: instance A uses the
// default configuration (PRESCALE = 1) and instance B uses PRESCALE = 4.
// Each is checked every cycle against a behavioural model that keeps the
// count as an integer modulo MAX+1, the prescaler as a modulo-PRESCALE
// cycle counter, and the lap FIFO as a queue. Directed scenarios come first,
// followed by randomized control traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_lap_stopwatch;

  localparam int DW    = 16;
  localparam int MAXV  = 99;
  localparam int DEPTH = 4;
  localparam int PRE_A = 1;
  localparam int PRE_B = 4;

  logic clk = 1'b0;
  logic resetn, start, stop, clear, dir, lap, lap_rd;

  logic [DW-1:0] count_a, lap_data_a, count_b, lap_data_b;
  logic running_a, wrap_a, lap_valid_a, lap_full_a, lap_overflow_a;
  logic running_b, wrap_b, lap_valid_b, lap_full_b, lap_overflow_b;

  always #5 clk = ~clk;

  lap_stopwatch #(.DATA_WIDTH(DW), .MAX(MAXV), .PRESCALE(PRE_A), .LAP_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .lap(lap), .lap_rd(lap_rd),
    .count(count_a), .running(running_a), .wrap(wrap_a), .lap_data(lap_data_a),
    .lap_valid(lap_valid_a), .lap_full(lap_full_a), .lap_overflow(lap_overflow_a)
  );

  lap_stopwatch #(.DATA_WIDTH(DW), .MAX(MAXV), .PRESCALE(PRE_B), .LAP_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .lap(lap), .lap_rd(lap_rd),
    .count(count_b), .running(running_b), .wrap(wrap_b), .lap_data(lap_data_b),
    .lap_valid(lap_valid_b), .lap_full(lap_full_b), .lap_overflow(lap_overflow_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------- reference model ----------------------------
  int m_cnt   [2];
  int m_presc [2];
  bit m_run   [2];
  bit m_wrap  [2];
  bit m_ovf   [2];
  int q_a [$];
  int q_b [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_run[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_edge(input int i, input bit st, sp, cl, d, lp, rd);
    int c, sz, p;
    c  = m_cnt[i];
    sz = (i == 0) ? q_a.size() : q_b.size();
    p  = (i == 0) ? PRE_A : PRE_B;
    // Lap FIFO: pop (if anything to pop) frees room before the push.
    if (rd && sz > 0) begin
      if (i == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      sz--;
    end
    if (lp) begin
      if (sz == DEPTH) m_ovf[i] = 1'b1;
      else if (i == 0) q_a.push_back(c);
      else q_b.push_back(c);
    end
    // Run control and counting.
    m_wrap[i] = 1'b0;
    if (cl) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_run[i] = 1'b0;
    end else if (sp) begin
      m_run[i] = 1'b0;
    end else if (st || m_run[i]) begin
      m_run[i]   = 1'b1;
      m_presc[i] = (m_presc[i] + 1) % p;
      if (m_presc[i] == 0) begin
        if (!d) begin
          m_cnt[i]  = (c + 1) % (MAXV + 1);
          m_wrap[i] = (m_cnt[i] == 0);
        end else begin
          m_cnt[i]  = (c + MAXV) % (MAXV + 1);
          m_wrap[i] = (m_cnt[i] == MAXV);
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a.count",    count_a,        m_cnt[0]);
    check("a.running",  running_a,      m_run[0]);
    check("a.wrap",     wrap_a,         m_wrap[0]);
    check("a.valid",    lap_valid_a,    q_a.size() > 0);
    check("a.full",     lap_full_a,     q_a.size() == DEPTH);
    check("a.overflow", lap_overflow_a, m_ovf[0]);
    if (q_a.size() > 0) check("a.lap_data", lap_data_a, q_a[0]);
    check("b.count",    count_b,        m_cnt[1]);
    check("b.running",  running_b,      m_run[1]);
    check("b.wrap",     wrap_b,         m_wrap[1]);
    check("b.valid",    lap_valid_b,    q_b.size() > 0);
    check("b.full",     lap_full_b,     q_b.size() == DEPTH);
    check("b.overflow", lap_overflow_b, m_ovf[1]);
    if (q_b.size() > 0) check("b.lap_data", lap_data_b, q_b[0]);
  endtask

  // One clock cycle: drive at the falling edge, model the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input bit st, sp, cl, d, lp, rd);
    start = st; stop = sp; clear = cl; dir = d; lap = lp; lap_rd = rd;
    @(posedge clk);
    model_edge(0, st, sp, cl, d, lp, rd);
    model_edge(1, st, sp, cl, d, lp, rd);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic async_reset();
    start = 0; stop = 0; clear = 0; dir = 0; lap = 0; lap_rd = 0;
    #2 resetn = 1'b0;
    #1;
    check("rst.a.count",    count_a,        0);
    check("rst.a.running",  running_a,      0);
    check("rst.a.wrap",     wrap_a,         0);
    check("rst.a.valid",    lap_valid_a,    0);
    check("rst.a.full",     lap_full_a,     0);
    check("rst.a.overflow", lap_overflow_a, 0);
    check("rst.a.lap_data", lap_data_a,     0);
    check("rst.b.count",    count_b,        0);
    check("rst.b.running",  running_b,      0);
    check("rst.b.valid",    lap_valid_b,    0);
    check("rst.b.overflow", lap_overflow_b, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_pop [4];
    bit r_dir;
    resetn = 1'b0;
    start = 0; stop = 0; clear = 0; dir = 0; lap = 0; lap_rd = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Free-running count with PRESCALE = 1: 1,2,...,99,0,1.
    cyc(1, 0, 0, 0, 0, 0);
    check("run.first_step", count_a, 1);
    for (int k = 2; k <= 101; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (k == 100) begin
        check("run.wrap_count", count_a, 0);
        check("run.wrap_pulse", wrap_a, 1);
      end
      if (k == 101) begin
        check("run.after_wrap", count_a, 1);
        check("run.wrap_low", wrap_a, 0);
        check("run.still_running", running_a, 1);
      end
    end

    // PRESCALE = 4: ten active cycles, stop, then resume.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(9);
    cyc(0, 1, 0, 0, 0, 0);
    check("pre.stopped_count", count_b, 2);
    check("pre.stopped_run", running_b, 0);
    idle(3);
    check("pre.held_count", count_b, 2);
    cyc(1, 0, 0, 0, 0, 0);
    check("pre.resume1", count_b, 2);
    cyc(0, 0, 0, 0, 0, 0);
    check("pre.resume2", count_b, 3);

    // Down through zero and back up through MAX.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("down.count", count_a, 99);
    check("down.wrap", wrap_a, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("up.count", count_a, 0);
    check("up.wrap", wrap_a, 1);

    // clear beats stop beats start.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(36);
    check("prio.setup", count_a, 37);
    cyc(1, 1, 1, 0, 0, 0);
    check("prio.count", count_a, 0);
    check("prio.running", running_a, 0);

    // Five laps into a four-entry FIFO.
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) cyc(0, 0, 0, 0, (c % 2 == 1) && (c >= 3), 0);
    check("lap.full", lap_full_a, 1);
    check("lap.overflow", lap_overflow_a, 1);
    cyc(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      check("lap.pop_value", lap_data_a, 3 + 2 * j);
      cyc(0, 0, 0, 0, 0, 1);
    end
    check("lap.empty", lap_valid_a, 0);

    // Reset mid-run, then push+pop on a full FIFO.
    cyc(1, 0, 0, 0, 1, 0);
    idle(5);
    async_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) cyc(0, 0, 0, 0, 1, 0);
    check("pp.full", lap_full_a, 1);
    check("pp.head_before", lap_data_a, 1);
    cyc(0, 0, 0, 0, 1, 1);
    check("pp.still_full", lap_full_a, 1);
    check("pp.no_overflow", lap_overflow_a, 0);
    check("pp.head_after", lap_data_a, 2);
    exp_pop = '{2, 3, 4, 5};
    cyc(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      check("pp.pop_value", lap_data_a, exp_pop[j]);
      cyc(0, 0, 0, 0, 0, 1);
    end
    check("pp.empty", lap_valid_a, 0);
    check("pp.empty_push_pop_setup", lap_full_a, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("pp.empty_push_pop", lap_valid_a, 1);

    // Randomized traffic.
    r_dir = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) r_dir = ~r_dir;
      if ($urandom_range(499) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(31) == 0,
            r_dir, $urandom_range(3) == 0, $urandom_range(3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
